spi2wb: RTL and testbench

SPI2WB -- requirements
Module: spi2wb

---
 rtl/spi2wb_if.sv | 17 +
 rtl/spi2wb.sv | 193 +++++++++++++++++++
 tb/tb_spi2wb.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi2wb_if.sv
// Wishbone initiator bus of the SPI-to-Wishbone bridge (byte data, 23-bit byte address).
interface spi2wb_if;
    localparam int unsigned AW = 23;
    localparam int unsigned DW = 8;

    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;

    modport master (output cyc_o, stb_o, we_o, adr_o, dat_o, input dat_i, ack_i, err_i);
    modport slave  (input cyc_o, stb_o, we_o, adr_o, dat_o, output dat_i, ack_i, err_i);
endinterface

// File: rtl/spi2wb.sv
// SPI mode-0 target bridging to a Wishbone initiator: cmd 0x03 read / 0x02 write, 24-bit address, byte data.
// Define SPI2WB_BURST_EN for auto-incrementing multi-byte bursts; default build handles a single data byte.
module spi2wb #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     sck,
    input  logic     mosi,
    input  logic     ss_n,
    output logic     miso,
    spi2wb_if.master wb
);
    localparam int unsigned AW = 23;
    localparam int unsigned CW = 5;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
    logic          sck_q, ss_q;
    logic          sck_s, mosi_s, ss_s, rise_c, fall_c;
    logic [CW-1:0] cnt_q;
    logic [6:0]    rx_q;
    logic [7:0]    tx_q, byte_c;
    logic [AW-2:0] addr_q;
    logic [AW-1:0] addr_c;
    logic          rd_q, fall_seen_q, first_q, done_q;
`ifdef SPI2WB_BURST_EN
    logic [2:0]    fcnt_q;
    logic [7:0]    nxt_q;
    logic          nxt_vld_q;
`endif

    // Input synchronizers plus previous-value registers for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            sck_q     <= sck_s;
            ss_q      <= ss_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign rise_c = sck_s & ~sck_q;
    assign fall_c = ~sck_s & sck_q;
    assign byte_c = {rx_q, mosi_s};
    assign addr_c = {addr_q, mosi_s};
    assign miso   = tx_q[7];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (ss_q) state_d = CMD;
                CMD:     if (rise_c && cnt_q == CW'(7))
                             state_d = (byte_c == 8'h03 || byte_c == 8'h02) ? ADDR : IGNORE;
                ADDR:    if (rise_c && cnt_q == CW'(23)) state_d = DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            fall_seen_q <= 1'b0;
            first_q     <= 1'b1;
            done_q      <= 1'b0;
            wb.cyc_o    <= 1'b0;
            wb.stb_o    <= 1'b0;
            wb.we_o     <= 1'b0;
            wb.adr_o    <= '0;
            wb.dat_o    <= '0;
`ifdef SPI2WB_BURST_EN
            fcnt_q      <= '0;
            nxt_q       <= '0;
            nxt_vld_q   <= 1'b0;
`endif
        end else begin
            if (state_d != state_q) cnt_q <= '0;
            else if (rise_c)        cnt_q <= (state_q == DATA) ? CW'(cnt_q[2:0] + 3'd1) : cnt_q + CW'(1);

            case (state_q)
                CMD: if (rise_c) begin
                    rx_q <= byte_c[6:0];
                    if (cnt_q == CW'(7)) rd_q <= (byte_c == 8'h03);
                end
                ADDR: if (rise_c) begin
                    addr_q <= addr_c[AW-2:0];
                    if (cnt_q == CW'(23)) begin
                        wb.adr_o <= addr_c;
                        if (rd_q && !wb.cyc_o) begin
                            wb.cyc_o <= 1'b1;
                            wb.stb_o <= 1'b1;
                            wb.we_o  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (rise_c) rx_q <= byte_c[6:0];
                    // Completed write byte: issue one Wishbone write
                    if (rise_c && cnt_q == CW'(7) && !rd_q && !done_q) begin
                        first_q <= 1'b0;
                        if (!wb.cyc_o) begin
                            wb.dat_o <= byte_c;
                            wb.cyc_o <= 1'b1;
                            wb.stb_o <= 1'b1;
                            wb.we_o  <= 1'b1;
`ifdef SPI2WB_BURST_EN
                            if (!first_q) wb.adr_o <= wb.adr_o + AW'(1);
`endif
                        end
`ifndef SPI2WB_BURST_EN
                        done_q <= 1'b1;
`endif
                    end
                    // First falling edge of a byte presents bit 7 without shifting
                    if (fall_c) begin
                        if (!fall_seen_q) begin
                            fall_seen_q <= 1'b1;
`ifdef SPI2WB_BURST_EN
                            fcnt_q <= '0;
                            if (!first_q) tx_q <= nxt_vld_q ? nxt_q : 8'h00;
`endif
                        end else begin
                            tx_q <= {tx_q[6:0], 1'b0};
`ifdef SPI2WB_BURST_EN
                            fcnt_q <= fcnt_q + 3'd1;
                            if (rd_q && fcnt_q == 3'd6) begin
                                fall_seen_q <= 1'b0;
                                first_q     <= 1'b0;
                                nxt_vld_q   <= 1'b0;
                                wb.adr_o    <= wb.adr_o + AW'(1);
                                if (!wb.cyc_o) begin
                                    wb.cyc_o <= 1'b1;
                                    wb.stb_o <= 1'b1;
                                    wb.we_o  <= 1'b0;
                                end
                            end
`endif
                        end
                    end
                end
                default: begin
                    tx_q        <= '0;
                    fall_seen_q <= 1'b0;
                    first_q     <= 1'b1;
                    done_q      <= 1'b0;
`ifdef SPI2WB_BURST_EN
                    nxt_vld_q   <= 1'b0;
`endif
                end
            endcase

            // Termination; read data is only usable before the byte's first falling edge
            if (wb.cyc_o && (wb.ack_i || wb.err_i)) begin
                wb.cyc_o <= 1'b0;
                wb.stb_o <= 1'b0;
                if (!wb.we_o && state_q == DATA && !fall_seen_q) begin
                    if (first_q) tx_q <= wb.err_i ? 8'h00 : wb.dat_i;
`ifdef SPI2WB_BURST_EN
                    else begin
                        nxt_q     <= wb.err_i ? 8'h00 : wb.dat_i;
                        nxt_vld_q <= 1'b1;
                    end
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_spi2wb.sv
// Scoreboard bench for spi2wb: directed SPI frames, a Wishbone responder/monitor and a MISO byte monitor.
`timescale 1ns/1ps
module tb_spi2wb;
    localparam int unsigned HALF = 6;

    typedef struct packed {
        logic [22:0] adr;
        logic        we;
        logic [7:0]  dat;
    } wb_exp_t;
    typedef logic [7:0] frame_t [8];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sck   = 1'b0;
    logic mosi  = 1'b0;
    logic ss_n  = 1'b1;
    logic miso;

    spi2wb_if wbif ();

    spi2wb #(.SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .sck   (sck),
        .mosi  (mosi),
        .ss_n  (ss_n),
        .miso  (miso),
        .wb    (wbif)
    );

    int          checks = 0;
    int          errors = 0;
    wb_exp_t     exp_wb[$];
    logic [7:0]  exp_miso[$];
    int unsigned rsp_delay = 0;
    logic [7:0]  rsp_data  = 8'h00;
    logic        rsp_err   = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic wb_exp_t mk(input logic [22:0] a, input logic w, input logic [7:0] d);
        wb_exp_t e;
        e.adr = a;
        e.we  = w;
        e.dat = d;
        return e;
    endfunction

    task automatic exp_bytes(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) exp_miso.push_back(v);
    endtask

    task automatic spi_frame(input frame_t b, input int nbits);
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[i/8][7 - (i % 8)];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HALF + 4) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    // Wishbone responder and transaction monitor
    initial begin : wb_side
        wb_exp_t e;
        wbif.ack_i = 1'b0;
        wbif.err_i = 1'b0;
        wbif.dat_i = 8'h00;
        forever begin
            @(negedge clk);
            if (wbif.cyc_o === 1'b1) begin
                check("wb_stb", 32'(wbif.stb_o), 32'd1);
                if (exp_wb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: cycle adr 0x%0h we %0d, expected no cycle", wbif.adr_o, wbif.we_o);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_adr", 32'(wbif.adr_o), 32'(e.adr));
                    check("wb_we", 32'(wbif.we_o), 32'(e.we));
                    if (e.we) check("wb_dat", 32'(wbif.dat_o), 32'(e.dat));
                end
                repeat (rsp_delay) @(negedge clk);
                wbif.dat_i = rsp_data;
                wbif.err_i = rsp_err;
                wbif.ack_i = !rsp_err;
                @(negedge clk);
                wbif.ack_i = 1'b0;
                wbif.err_i = 1'b0;
                wbif.dat_i = 8'h00;
                check("wb_cyc_drop", 32'(wbif.cyc_o), 32'd0);
            end
        end
    end

    // MISO monitor: assemble bytes sampled on sck rising edges within a frame
    initial begin : miso_mon
        logic [7:0] sh;
        int nb;
        sh = 8'h00;
        nb = 0;
        forever begin
            @(posedge sck or negedge ss_n);
            if (sck && !ss_n) begin
                sh = {sh[6:0], miso};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_miso.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL miso_unexpected: byte 0x%0h, expected none", sh);
                    end else begin
                        check("miso_byte", 32'(sh), 32'(exp_miso.pop_front()));
                    end
                end
            end else begin
                nb = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        frame_t f;
        repeat (3) @(negedge clk);
        check("rst_cyc",  32'(wbif.cyc_o), 32'd0);
        check("rst_stb",  32'(wbif.stb_o), 32'd0);
        check("rst_we",   32'(wbif.we_o),  32'd0);
        check("rst_adr",  32'(wbif.adr_o), 32'd0);
        check("rst_dat",  32'(wbif.dat_o), 32'd0);
        check("rst_miso", 32'(miso),       32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_miso", 32'(miso), 32'd0);

        // Write 02 00 12 34 A5, ack one cycle later
        rsp_delay = 1; rsp_data = 8'h00; rsp_err = 1'b0;
        f = '{8'h02, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h001234, 1'b1, 8'hA5));
        exp_bytes(8'h00, 5);
        spi_frame(f, 40);

        // Read 03 7F FF FF, zero-wait 0x3C
        rsp_delay = 0; rsp_data = 8'h3C;
        f = '{8'h03, 8'h7F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h7FFFFF, 1'b0, 8'h00));
`ifdef SPI2WB_BURST_EN
        exp_wb.push_back(mk(23'h000000, 1'b0, 8'h00));
`endif
        exp_bytes(8'h00, 4);
        exp_bytes(8'h3C, 1);
        spi_frame(f, 40);

        // Read with ack arriving after the first data falling edge
        rsp_delay = 20; rsp_data = 8'h5A;
        f = '{8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h000010, 1'b0, 8'h00));
`ifdef SPI2WB_BURST_EN
        exp_wb.push_back(mk(23'h000011, 1'b0, 8'h00));
`endif
        exp_bytes(8'h00, 5);
        spi_frame(f, 40);
        repeat (40) @(negedge clk);

        // Read terminated by err_i: data taken as zero
        rsp_delay = 0; rsp_data = 8'hAA; rsp_err = 1'b1;
        f = '{8'h03, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h000020, 1'b0, 8'h00));
`ifdef SPI2WB_BURST_EN
        exp_wb.push_back(mk(23'h000021, 1'b0, 8'h00));
`endif
        exp_bytes(8'h00, 5);
        spi_frame(f, 40);
        rsp_err = 1'b0;

        // Unknown command 0x9F followed by 32 clocks
        f = '{8'h9F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        exp_bytes(8'h00, 5);
        spi_frame(f, 40);

        // Write aborted after 5 data bits, then a normal write
        rsp_delay = 1;
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h00, 8'h00};
        exp_bytes(8'h00, 4);
        spi_frame(f, 37);
        f = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h11, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h000001, 1'b1, 8'h11));
        exp_bytes(8'h00, 5);
        spi_frame(f, 40);

        // Two-byte write
        f = '{8'h02, 8'h00, 8'h00, 8'h05, 8'hAA, 8'hBB, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h000005, 1'b1, 8'hAA));
`ifdef SPI2WB_BURST_EN
        exp_wb.push_back(mk(23'h000006, 1'b1, 8'hBB));
`endif
        exp_bytes(8'h00, 6);
        spi_frame(f, 48);

        // Two-byte read
        rsp_delay = 0; rsp_data = 8'h81;
        f = '{8'h03, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h000040, 1'b0, 8'h00));
        exp_bytes(8'h00, 4);
        exp_bytes(8'h81, 1);
`ifdef SPI2WB_BURST_EN
        exp_wb.push_back(mk(23'h000041, 1'b0, 8'h00));
        exp_wb.push_back(mk(23'h000042, 1'b0, 8'h00));
        exp_bytes(8'h81, 1);
`else
        exp_bytes(8'h00, 1);
`endif
        spi_frame(f, 48);

`ifdef SPI2WB_BURST_EN
        // Burst write wrapping the address space
        rsp_delay = 1;
        f = '{8'h02, 8'h7F, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00};
        exp_wb.push_back(mk(23'h7FFFFF, 1'b1, 8'h11));
        exp_wb.push_back(mk(23'h000000, 1'b1, 8'h22));
        exp_bytes(8'h00, 6);
        spi_frame(f, 48);
`endif

        repeat (50) @(negedge clk);
        check("end_miso",         32'(miso),            32'd0);
        check("wb_queue_empty",   32'(exp_wb.size()),   32'd0);
        check("miso_queue_empty", 32'(exp_miso.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
